instr_prefetch_queue: RTL and testbench

Instruction prefetch unit sitting directly upstream of the fetch stage, between the instruction memory port and the fetch/decode pipeline register. It runs ahead of the pipeline, issuing sequential word reads over a req/ack memory handshake and buffering returned instructions with their PC+4 in a small FIFO. It presents one instruction per cycle to fetch, honours fetch stalls, and flushes on taken branches/jumps from decode.

---
 rtl/instr_prefetch_queue_pkg.sv | 19 +
 rtl/prefetch_fifo.sv | 58 +++++
 rtl/instr_prefetch_queue.sv | 101 ++++++++++
 tb/tb_instr_prefetch_queue.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_prefetch_queue_pkg.sv
// Shared CPU-front-end definitions used by the instruction prefetch queue.
package cpu_defs;

    localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES   = 32'd4;

    typedef enum logic [1:0] {
        PF_IDLE = 2'd0,
        PF_WAIT = 2'd1,
        PF_DROP = 2'd2
    } pf_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus_4;
    } pf_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO holding prefetched {instr, pc+4} entries; flush wins over push/pop.
module prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Sequential instruction prefetcher: req/ack memory reader feeding a small FIFO to fetch.
module instr_prefetch_queue
    import cpu_defs::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        pc_src_d,
    input  logic [31:0] pc_branch_d,
    input  logic        stall_f,
    output logic [31:0] instruction_f,
    output logic [31:0] pc_plus_4_f,
    output logic        valid_f,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    pf_state_e   state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] addr_q, addr_d;

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    pf_entry_t     fifo_wdata, fifo_head;

    assign valid_f  = !fifo_empty;
    assign mem_req  = (state_q != PF_IDLE);
    assign mem_addr = addr_q;

    // A redirect kills both the returning word and the head being consumed.
    assign fifo_push = (state_q == PF_WAIT) && mem_ack && !pc_src_d && !fifo_full;
    assign fifo_pop  = valid_f && !stall_f && !pc_src_d;

    assign fifo_wdata.instr     = mem_rdata;
    assign fifo_wdata.pc_plus_4 = addr_q + WORD_BYTES;

    assign instruction_f = valid_f ? fifo_head.instr     : NOP_INSTR;
    assign pc_plus_4_f   = valid_f ? fifo_head.pc_plus_4 : 32'h0;

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(pf_entry_t))
    ) u_fifo (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .flush_i (pc_src_d),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        case (state_q)
            PF_IDLE: begin
                // Only issued from IDLE, so no request is in flight to reserve a slot for.
                if (!pc_src_d && (fifo_count < DEPTH_C)) begin
                    state_d = PF_WAIT;
                    addr_d  = fetch_pc_q;
                end
            end
            PF_WAIT: begin
                if (mem_ack)       state_d = PF_IDLE;
                else if (pc_src_d) state_d = PF_DROP;
            end
            PF_DROP: begin
                if (mem_ack) state_d = PF_IDLE;
            end
            default: state_d = PF_IDLE;
        endcase

        if (pc_src_d)       fetch_pc_d = pc_branch_d & ~32'h3;
        else if (fifo_push) fetch_pc_d = fetch_pc_q + WORD_BYTES;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= PF_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue with a bench-side memory responder.
module tb_instr_prefetch_queue;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        pc_src_d = 1'b0;
    logic [31:0] pc_branch_d = 32'h0;
    logic        stall_f = 1'b0;
    logic [31:0] instruction_f, pc_plus_4_f, mem_addr;
    logic        valid_f, mem_req;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int errors = 0;
    int checks = 0;
    int delivered = 0;
    int acks = 0;
    int d0, a0;
    bit auto_ack = 1'b0;
    bit wrap_seen = 1'b0;
    logic [31:0] exp_req, exp_head;

    instr_prefetch_queue #(.DEPTH(4), .RESET_PC(RST_PC)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .pc_src_d      (pc_src_d),
        .pc_branch_d   (pc_branch_d),
        .stall_f       (stall_f),
        .instruction_f (instruction_f),
        .pc_plus_4_f   (pc_plus_4_f),
        .valid_f       (valid_f),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'hC3A5_5A3C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called with the clock low; advances one full cycle and returns at the next negedge.
    task automatic step();
        if (auto_ack) begin
            mem_ack = mem_req;
            if (mem_req) begin
                chk("req_addr", mem_addr, exp_req);
                mem_rdata = mdata(mem_addr);
                acks++;
                if (!pc_src_d) exp_req = exp_req + 32'd4;
            end
        end
        if (valid_f && !stall_f && !pc_src_d) begin
            chk("deliver_instr", instruction_f, mdata(exp_head));
            chk("deliver_pc4", pc_plus_4_f, exp_head + 32'd4);
            if (exp_head == 32'hFFFF_FFFC && pc_plus_4_f == 32'h0) wrap_seen = 1'b1;
            exp_head = exp_head + 32'd4;
            delivered++;
        end
        @(posedge clock);
        @(negedge clock);
        if (auto_ack) mem_ack = 1'b0;
    endtask

    initial begin
        // Reset values must appear without any clock edge.
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_req", mem_req, 1'b0);
        chk("rst_addr", mem_addr, RST_PC);
        chk("rst_valid", valid_f, 1'b0);
        chk("rst_instr", instruction_f, 32'h0);
        chk("rst_pc4", pc_plus_4_f, 32'h0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        exp_req = RST_PC;
        exp_head = RST_PC;

        // Streaming with immediate ack, no stall.
        auto_ack = 1'b1;
        step();
        chk("first_req", mem_req, 1'b1);
        chk("first_addr", mem_addr, RST_PC);
        chk("first_valid", valid_f, 1'b0);
        step();
        chk("first_push_valid", valid_f, 1'b1);
        chk("first_push_instr", instruction_f, mdata(RST_PC));
        chk("first_push_pc4", pc_plus_4_f, 32'h0040_0004);
        chk("bubble_req", mem_req, 1'b0);
        repeat (11) step();
        chk("stream_cnt", delivered, 6);

        // Stall for 10 cycles: the queue fills to DEPTH and requests stop.
        stall_f = 1'b1;
        a0 = acks;
        repeat (10) step();
        chk("stall_acks", acks - a0, 4);
        chk("stall_req_off", mem_req, 1'b0);
        chk("stall_valid", valid_f, 1'b1);
        chk("stall_head", instruction_f, mdata(32'h0040_0018));
        stall_f = 1'b0;
        repeat (10) step();
        chk("drain_cnt", delivered, 14);

        // Redirect while waiting; the late word must be dropped.
        auto_ack = 1'b0;
        for (int i = 0; i < 10 && !mem_req; i++) step();
        chk("t3_wait_req", mem_req, 1'b1);
        pc_src_d = 1'b1;
        pc_branch_d = 32'h0040_0100;
        step();
        pc_src_d = 1'b0;
        chk("drop_valid", valid_f, 1'b0);
        chk("drop_req_held", mem_req, 1'b1);
        chk("drop_addr_stable", mem_addr, exp_req);
        step();
        step();
        chk("drop_req_held2", mem_req, 1'b1);
        mem_ack = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_ack = 1'b0;
        chk("drop_discard_valid", valid_f, 1'b0);
        chk("drop_idle_req", mem_req, 1'b0);
        step();
        chk("redir_req", mem_req, 1'b1);
        chk("redir_addr", mem_addr, 32'h0040_0100);
        exp_req = 32'h0040_0100;
        exp_head = 32'h0040_0100;
        auto_ack = 1'b1;
        repeat (6) step();

        // Redirect coinciding with ack and a pop.
        stall_f = 1'b1;
        for (int i = 0; i < 20 && !(mem_req && valid_f); i++) step();
        chk("t4_req", mem_req, 1'b1);
        chk("t4_valid", valid_f, 1'b1);
        auto_ack = 1'b0;
        stall_f = 1'b0;
        pc_src_d = 1'b1;
        pc_branch_d = 32'h0040_0203;
        mem_ack = 1'b1;
        mem_rdata = mdata(mem_addr);
        step();
        mem_ack = 1'b0;
        pc_src_d = 1'b0;
        chk("t4_flush_valid", valid_f, 1'b0);
        chk("t4_flush_instr", instruction_f, 32'h0);
        chk("t4_flush_pc4", pc_plus_4_f, 32'h0);
        chk("t4_idle", mem_req, 1'b0);
        step();
        chk("t4_req_target", mem_req, 1'b1);
        chk("t4_addr_aligned", mem_addr, 32'h0040_0200);
        exp_req = 32'h0040_0200;
        exp_head = 32'h0040_0200;
        auto_ack = 1'b1;
        repeat (6) step();

        // Address wrap past 0xFFFF_FFFC.
        auto_ack = 1'b0;
        pc_src_d = 1'b1;
        pc_branch_d = 32'hFFFF_FFF8;
        step();
        pc_src_d = 1'b0;
        if (mem_req) begin
            mem_ack = 1'b1;
            mem_rdata = 32'hDEAD_BEEF;
            step();
            mem_ack = 1'b0;
        end
        exp_req = 32'hFFFF_FFF8;
        exp_head = 32'hFFFF_FFF8;
        auto_ack = 1'b1;
        repeat (10) step();
        chk("wrap_seen", {31'h0, wrap_seen}, 32'h1);

        // Asynchronous reset in the middle of a request.
        auto_ack = 1'b0;
        for (int i = 0; i < 10 && !mem_req; i++) step();
        chk("t6_wait_req", mem_req, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("arst_req", mem_req, 1'b0);
        chk("arst_addr", mem_addr, RST_PC);
        chk("arst_valid", valid_f, 1'b0);
        chk("arst_instr", instruction_f, 32'h0);
        chk("arst_pc4", pc_plus_4_f, 32'h0);
        mem_ack = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        @(negedge clock);
        chk("arst_late_ack", valid_f, 1'b0);
        reset_n = 1'b1;
        mem_ack = 1'b0;
        step();
        chk("restart_req", mem_req, 1'b1);
        chk("restart_addr", mem_addr, RST_PC);
        chk("restart_valid", valid_f, 1'b0);
        exp_req = RST_PC;
        exp_head = RST_PC;
        d0 = delivered;
        auto_ack = 1'b1;
        repeat (6) step();
        chk("restart_cnt", delivered - d0, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
